// File: rtl/series_pipe_ctrl.sv
// series_pipe_ctrl: sends one operand through an external PIPE_LAT-stage pipe
// up to PASSES times. Each trip's outputs become the next trip's inputs, and
// an overflow on any trip ends the evaluation early.
module series_pipe_ctrl #(
  parameter int          PIPE_LAT     = 4,
  parameter int          PASSES       = 2,
  parameter logic [3:0]  SEL_SUM_MASK = 4'b0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        overflow,
  output logic [31:0] pipe_x,
  output logic [31:0] pipe_num,
  output logic [31:0] pipe_sum,
  output logic        pipe_ovf,
  output logic        addr_stage1,
  output logic        addr_stage2,
  output logic        addr_stage3,
  output logic        addr_stage4,
  output logic        sel_sum_stage1,
  output logic        sel_sum_stage2,
  output logic        sel_sum_stage3,
  output logic        sel_sum_stage4,
  input  logic [31:0] out_x,
  input  logic [31:0] out_num,
  input  logic [31:0] out_sum,
  input  logic        overflow_out
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  // Wait count at which the pipe output for the current trip is valid.
  localparam logic [7:0] LAST_CNT  = 8'(PIPE_LAT);
  // Index of the final trip; trips are numbered from 0.
  localparam logic       LAST_PASS = 1'(PASSES - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       pass_idx;

  // Sum-select lines are fixed strapping taken straight from the mask.
  assign sel_sum_stage1 = SEL_SUM_MASK[0];
  assign sel_sum_stage2 = SEL_SUM_MASK[1];
  assign sel_sum_stage3 = SEL_SUM_MASK[2];
  assign sel_sum_stage4 = SEL_SUM_MASK[3];

  // Controller FSM. It accepts a start in IDLE or FIN, holds the pipe inputs
  // for a whole trip, then either loops the pipe outputs back for another trip
  // or latches the result. The coefficient-bank select is delayed one cycle per
  // stage so that each stage sees the bank matching the data it is holding.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      pass_idx    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      overflow    <= 1'b0;
      pipe_x      <= '0;
      pipe_num    <= '0;
      pipe_sum    <= '0;
      pipe_ovf    <= 1'b0;
      addr_stage1 <= 1'b0;
      addr_stage2 <= 1'b0;
      addr_stage3 <= 1'b0;
      addr_stage4 <= 1'b0;
    end else begin
      done        <= 1'b0;
      addr_stage2 <= addr_stage1;
      addr_stage3 <= addr_stage2;
      addr_stage4 <= addr_stage3;
      case (state)
        IDLE, FIN: begin
          if (start) begin
            state       <= RUN;
            busy        <= 1'b1;
            cnt         <= '0;
            pass_idx    <= 1'b0;
            pipe_x      <= x_in;
            pipe_num    <= 32'h7FFF_FFFF;
            pipe_sum    <= '0;
            pipe_ovf    <= 1'b0;
            addr_stage1 <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (cnt == LAST_CNT) begin
            if ((pass_idx != LAST_PASS) && !overflow_out) begin
              pass_idx    <= pass_idx + 1'b1;
              addr_stage1 <= pass_idx + 1'b1;
              cnt         <= '0;
              pipe_x      <= out_x;
              pipe_num    <= out_num;
              pipe_sum    <= out_sum;
              pipe_ovf    <= overflow_out;
            end else begin
              result   <= out_sum;
              overflow <= overflow_out;
              state    <= FIN;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_series_pipe_ctrl.sv
// Testbench for series_pipe_ctrl: a behavioural 4-stage pipe drives the
// controller, and a trip-by-trip reference model predicts every observable.
`timescale 1ns/1ps
module tb_series_pipe_ctrl;

  localparam int         LAT      = 4;
  localparam int         NPASS    = 2;
  localparam logic [3:0] SEL_MASK = 4'b1010;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] num;
    logic [31:0] sum;
    logic        ovf;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] x_in;
  logic        busy, done, overflow, pipe_ovf;
  logic [31:0] result, pipe_x, pipe_num, pipe_sum;
  logic        addr_stage1, addr_stage2, addr_stage3, addr_stage4;
  logic        sel_sum_stage1, sel_sum_stage2, sel_sum_stage3, sel_sum_stage4;
  logic [31:0] out_x, out_num, out_sum;
  logic        overflow_out;
  logic        force_ovf;

  int   n_checks = 0;
  int   n_pass   = 0;
  logic prev_addr = 1'b0;

  beat_t stg [0:3];
  beat_t po;

  series_pipe_ctrl #(.PIPE_LAT(LAT), .PASSES(NPASS), .SEL_SUM_MASK(SEL_MASK)) dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in),
    .busy(busy), .done(done), .result(result), .overflow(overflow),
    .pipe_x(pipe_x), .pipe_num(pipe_num), .pipe_sum(pipe_sum), .pipe_ovf(pipe_ovf),
    .addr_stage1(addr_stage1), .addr_stage2(addr_stage2),
    .addr_stage3(addr_stage3), .addr_stage4(addr_stage4),
    .sel_sum_stage1(sel_sum_stage1), .sel_sum_stage2(sel_sum_stage2),
    .sel_sum_stage3(sel_sum_stage3), .sel_sum_stage4(sel_sum_stage4),
    .out_x(out_x), .out_num(out_num), .out_sum(out_sum), .overflow_out(overflow_out)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  // Arithmetic performed by one full trip through the pipe.
  function automatic beat_t pipe_f(beat_t i);
    beat_t       o;
    logic [32:0] s;
    s     = {1'b0, i.sum} + {1'b0, i.x};
    o.x   = i.x * 32'd3 + 32'd1;
    o.num = i.num - i.x;
    o.sum = s[31:0];
    o.ovf = i.ovf | s[32];
    return o;
  endfunction

  initial for (int i = 0; i < 4; i++) stg[i] = '0;

  // Behavioural pipe: four register stages, output computed from the last one.
  always @(posedge clk) begin
    stg[0] <= {pipe_x, pipe_num, pipe_sum, pipe_ovf};
    for (int i = 1; i < 4; i++) stg[i] <= stg[i-1];
  end

  assign po           = pipe_f(stg[3]);
  assign out_x        = po.x;
  assign out_num      = po.num;
  assign out_sum      = po.sum;
  assign overflow_out = po.ovf | force_ovf;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
  endtask

  // Expected bank select in cycle S+j of a run.
  function automatic logic exp_addr(int j, logic two_pass);
    if (j <= 0) return prev_addr;
    return two_pass && (j >= LAT + 2);
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".busy"},     32'(busy),     32'd0);
    checkOutput({tag, ".done"},     32'(done),     32'd0);
    checkOutput({tag, ".result"},   result,        32'd0);
    checkOutput({tag, ".overflow"}, 32'(overflow), 32'd0);
    checkOutput({tag, ".pipe_x"},   pipe_x,        32'd0);
    checkOutput({tag, ".pipe_num"}, pipe_num,      32'd0);
    checkOutput({tag, ".pipe_sum"}, pipe_sum,      32'd0);
    checkOutput({tag, ".pipe_ovf"}, 32'(pipe_ovf), 32'd0);
    checkOutput({tag, ".addr"},
                32'({addr_stage4, addr_stage3, addr_stage2, addr_stage1}), 32'd0);
  endtask

  // One evaluation, started from a negedge in an IDLE or FIN cycle. With chain=1
  // the task returns in the FIN cycle so the caller can start the next one there.
  task automatic applyStimulus(input logic [31:0] x, input logic force0, input logic chain);
    beat_t       cur, o, p1_in;
    int          passes_run, done_k, last_k;
    logic        two_pass;
    logic [31:0] exp_res;
    logic        exp_ovf;
    cur        = '{x: x, num: 32'h7FFF_FFFF, sum: 32'd0, ovf: 1'b0};
    p1_in      = '0;
    passes_run = 0;
    two_pass   = 1'b0;
    exp_res    = '0;
    exp_ovf    = 1'b0;
    for (int p = 0; p < NPASS; p++) begin
      o = pipe_f(cur);
      if (force0 && p == 0) o.ovf = 1'b1;
      passes_run++;
      if (o.ovf || p == NPASS - 1) begin
        exp_res = o.sum;
        exp_ovf = o.ovf;
        break;
      end
      cur      = o;
      p1_in    = o;
      two_pass = 1'b1;
    end
    done_k = 1 + passes_run * (LAT + 1);
    last_k = chain ? done_k : done_k + 2;

    start = 1'b1;
    x_in  = x;
    @(posedge clk);
    @(negedge clk);
    for (int k = 1; k <= last_k; k++) begin
      if (k > 1) @(negedge clk);
      if (k < done_k) begin
        start = 1'($urandom_range(0, 1));
        x_in  = $urandom;
      end else begin
        start = 1'b0;
      end
      force_ovf = force0 && (k == LAT + 1);
      if (k <= LAT + 1) begin
        checkOutput("p0.pipe_x",   pipe_x,        x);
        checkOutput("p0.pipe_num", pipe_num,      32'h7FFF_FFFF);
        checkOutput("p0.pipe_sum", pipe_sum,      32'd0);
        checkOutput("p0.pipe_ovf", 32'(pipe_ovf), 32'd0);
      end else if (two_pass && k < done_k) begin
        checkOutput("p1.pipe_x",   pipe_x,        p1_in.x);
        checkOutput("p1.pipe_num", pipe_num,      p1_in.num);
        checkOutput("p1.pipe_sum", pipe_sum,      p1_in.sum);
        checkOutput("p1.pipe_ovf", 32'(pipe_ovf), 32'd0);
      end
      checkOutput("busy", 32'(busy), 32'(k < done_k));
      checkOutput("done", 32'(done), 32'(k == done_k));
      if (k >= done_k) begin
        checkOutput("result",   result,        exp_res);
        checkOutput("overflow", 32'(overflow), 32'(exp_ovf));
      end
      checkOutput("addr1", 32'(addr_stage1), 32'(exp_addr(k,     two_pass)));
      checkOutput("addr2", 32'(addr_stage2), 32'(exp_addr(k - 1, two_pass)));
      checkOutput("addr3", 32'(addr_stage3), 32'(exp_addr(k - 2, two_pass)));
      checkOutput("addr4", 32'(addr_stage4), 32'(exp_addr(k - 3, two_pass)));
    end
    force_ovf = 1'b0;
    prev_addr = two_pass;
  endtask

  // Reset in cycle S+3 of a run: everything clears and no completion follows.
  task automatic resetMidRun(input logic [31:0] x);
    start = 1'b1;
    x_in  = x;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    checkAllZero("midrst");
    prev_addr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      checkOutput("midrst.no_done", 32'(done), 32'd0);
      @(negedge clk);
    end
  endtask

  // Main sequence: reset, directed runs, random runs, mid-run reset.
  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    x_in      = '0;
    force_ovf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    checkOutput("reset.sel_sum",
                32'({sel_sum_stage4, sel_sum_stage3, sel_sum_stage2, sel_sum_stage1}),
                32'(SEL_MASK));
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(32'hE000_0000, 1'b0, 1'b0);
    applyStimulus(32'hE000_0000, 1'b1, 1'b0);
    applyStimulus(32'h0000_0001, 1'b0, 1'b1);
    applyStimulus(32'h1234_5678, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++)
      applyStimulus($urandom, 1'(($urandom % 4) == 0), 1'(($urandom % 3) == 0));
    applyStimulus($urandom, 1'b0, 1'b0);
    resetMidRun(32'hCAFE_F00D);
    applyStimulus(32'h4000_0000, 1'b0, 1'b0);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety net so the run always ends even if something stalls.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not reach the end");
    $fatal(1, "[TB] timeout");
  end

endmodule
